// File: rtl/mci_pkg.sv
// mci_pkg: shared types and constants for the MCI CIF decoder.
// Also provides the assertion macros used by the decoder if no project-wide
// definition has been pulled in first.

`ifndef CALIPTRA_ASSERT_MUTEX
`define CALIPTRA_ASSERT_MUTEX(name, sig, clk, rst) \
  name: assert property (@(posedge clk) disable iff (rst) $onehot0(sig));
`endif

`ifndef CALIPTRA_ASSERT_INIT
`define CALIPTRA_ASSERT_INIT(name, cond, clk) \
  name: assert property (@(posedge clk) (cond));
`endif

package mci_pkg;

  typedef enum logic [1:0] {
    MCI_CIF_DEC_IDLE  = 2'd0,
    MCI_CIF_DEC_BUSY  = 2'd1,
    MCI_CIF_DEC_ABORT = 2'd2,
    MCI_CIF_DEC_DRAIN = 2'd3
  } mci_cif_dec_state_e;

  localparam int MCI_CIF_DEC_MAX_TGT = 16;

  // Default MCI map: 0 reg, 1 trace buffer, 2 mailbox0, 3 mailbox1, 4 SRAM
  localparam int MCI_CIF_DEC_DEF_NUM_TGT = 5;
  localparam logic [4:0][31:0] MCI_CIF_DEC_DEF_BASE = {
    32'h00C0_0000, 32'h0080_0000, 32'h0040_0000, 32'h0001_0000, 32'h0000_0000
  };
  localparam logic [4:0][31:0] MCI_CIF_DEC_DEF_LIMIT = {
    32'h00FF_FFFF, 32'h009F_FFFF, 32'h005F_FFFF, 32'h0001_0FFF, 32'h0000_0FFF
  };

endpackage

// File: rtl/cif_if.sv
// cif_if: CIF request/response bundle.
// req_data packs {addr, user, write, wstrb, wdata}, MSB first.
interface cif_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int USER_W = 32
) ();
  localparam int REQ_W = ADDR_W + USER_W + 1 + DATA_W/8 + DATA_W;

  logic              dv;
  logic [REQ_W-1:0]  req_data;
  logic              hold;
  logic              error;
  logic [DATA_W-1:0] rdata;

  modport request  (output dv, req_data, input  hold, error, rdata);
  modport response (input  dv, req_data, output hold, error, rdata);
endinterface

// File: rtl/mci_cif_priv_user_detect.sv
// mci_cif_priv_user_detect: flags a request whose AXI user matches one strap.
// An all-zeros strap disables the detector, an all-ones strap matches any user.
module mci_cif_priv_user_detect #(
  parameter int USER_W = 32
) (
  input  logic              dv,
  input  logic [USER_W-1:0] user,
  input  logic [USER_W-1:0] strap,
  output logic              priv
);

  // Strap decode: disabled / force-enable / exact match
  always_comb begin
    if (strap == '0) begin
      priv = 1'b0;
    end else if (&strap) begin
      priv = dv;
    end else begin
      priv = dv & (user == strap);
    end
  end

endmodule

// File: rtl/mci_cif_multi_decode.sv
// mci_cif_multi_decode: fans the SoC-side CIF response port out to NUM_TGT
// windowed targets. A held target is tracked by index so the address is not
// re-decoded mid-transaction. Defining MCI_CIF_DECODE_TIMEOUT_EN adds the hold
// timeout (ABORT/DRAIN states and timeout status); without it BUSY waits
// indefinitely and the timeout outputs are tied to 0.
module mci_cif_multi_decode
  import mci_pkg::*;
#(
  parameter int NUM_TGT  = 5,
  parameter int NUM_PRIV = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int USER_W   = 32,
  parameter logic [NUM_TGT-1:0][ADDR_W-1:0] TGT_BASE  = '{default:'0},
  parameter logic [NUM_TGT-1:0][ADDR_W-1:0] TGT_LIMIT = '{default:'0},
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1,
  localparam int REQ_W = ADDR_W + USER_W + 1 + DATA_W/8 + DATA_W
) (
  input  logic                              clk,
  input  logic                              rst_b,
  cif_if.response                           soc_resp_if,
  output logic [NUM_TGT-1:0]                tgt_dv,
  output logic [REQ_W-1:0]                  tgt_req_data,
  input  logic [NUM_TGT-1:0][DATA_W-1:0]    tgt_rdata,
  input  logic [NUM_TGT-1:0]                tgt_hold,
  input  logic [NUM_TGT-1:0]                tgt_error,
  input  logic [NUM_TGT-1:0]                tgt_en,
  input  logic [NUM_PRIV-1:0][USER_W-1:0]   strap_priv_user,
  output logic [NUM_PRIV-1:0]               priv_req,
  output logic                              timeout_pulse,
  output logic [IDX_W-1:0]                  timeout_tgt,
  output logic [7:0]                        timeout_cnt
);

  logic               dv;
  logic [ADDR_W-1:0]  req_addr;
  logic [USER_W-1:0]  req_user;
  logic [NUM_TGT-1:0] hit;
  logic [IDX_W-1:0]   hit_idx;

  mci_cif_dec_state_e state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   sel;
  logic               route;
  logic               soc_hold, soc_err;
  logic [DATA_W-1:0]  soc_rdata;

  assign dv           = soc_resp_if.dv;
  assign req_addr     = soc_resp_if.req_data[REQ_W-1 -: ADDR_W];
  assign req_user     = soc_resp_if.req_data[REQ_W-ADDR_W-1 -: USER_W];
  assign tgt_req_data = soc_resp_if.req_data;

  // Window decode; windows are disjoint so at most one bit is set
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      hit[i] = dv & tgt_en[i] & (req_addr >= TGT_BASE[i]) & (req_addr <= TGT_LIMIT[i]);
      if (hit[i]) hit_idx = IDX_W'(i);
    end
  end

`ifdef MCI_CIF_DECODE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tp_q, tp_d;
  logic [IDX_W-1:0] tt_q, tt_d;
  logic [7:0]       tc_q, tc_d;
`endif

  // Next state and SoC response steering
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    route     = 1'b0;
    sel       = idx_q;
    soc_hold  = 1'b0;
    soc_err   = 1'b0;
    soc_rdata = '0;
    tgt_dv    = '0;
    case (state_q)
      MCI_CIF_DEC_IDLE: begin
        if (|hit) begin
          route = 1'b1;
          sel   = hit_idx;
          if (tgt_hold[hit_idx]) begin
            state_d = MCI_CIF_DEC_BUSY;
            idx_d   = hit_idx;
          end
        end else if (dv) begin
          soc_err = 1'b1;
        end
      end
      MCI_CIF_DEC_BUSY: begin
        if (!dv) begin
          state_d = MCI_CIF_DEC_IDLE;
        end else begin
          route = 1'b1;
          if (!tgt_hold[idx_q]) begin
            state_d = MCI_CIF_DEC_IDLE;
          end
`ifdef MCI_CIF_DECODE_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = MCI_CIF_DEC_ABORT;
          end
`endif
        end
      end
`ifdef MCI_CIF_DECODE_TIMEOUT_EN
      MCI_CIF_DEC_ABORT: begin
        soc_err = 1'b1;
        state_d = MCI_CIF_DEC_DRAIN;
      end
      MCI_CIF_DEC_DRAIN: begin
        // stall any new request until the aborted target lets go
        soc_hold = dv;
        if (!tgt_hold[idx_q]) state_d = MCI_CIF_DEC_IDLE;
      end
`endif
      default: state_d = MCI_CIF_DEC_IDLE;
    endcase
    if (route) begin
      tgt_dv[sel] = 1'b1;
      soc_hold    = tgt_hold[sel];
      soc_err     = tgt_error[sel];
      soc_rdata   = tgt_rdata[sel];
    end
  end

  assign soc_resp_if.hold  = soc_hold;
  assign soc_resp_if.error = soc_err;
  assign soc_resp_if.rdata = soc_rdata;

`ifdef MCI_CIF_DECODE_TIMEOUT_EN
  // Hold counter and abort status; status registers change on BUSY->ABORT
  always_comb begin
    cnt_d = '0;
    if (state_q == MCI_CIF_DEC_IDLE && state_d == MCI_CIF_DEC_BUSY) begin
      cnt_d = CNT_W'(1);
    end else if (state_q == MCI_CIF_DEC_BUSY && state_d == MCI_CIF_DEC_BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tp_d = (state_q == MCI_CIF_DEC_BUSY) && (state_d == MCI_CIF_DEC_ABORT);
    tt_d = tp_d ? idx_q : tt_q;
    tc_d = (tp_d && tc_q != 8'hFF) ? tc_q + 8'd1 : tc_q;
  end

  // Timeout state registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
      tp_q  <= 1'b0;
      tt_q  <= '0;
      tc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      tp_q  <= tp_d;
      tt_q  <= tt_d;
      tc_q  <= tc_d;
    end
  end

  assign timeout_pulse = tp_q;
  assign timeout_tgt   = tt_q;
  assign timeout_cnt   = tc_q;
`else
  assign timeout_pulse = 1'b0;
  assign timeout_tgt   = '0;
  assign timeout_cnt   = '0;
`endif

  // FSM state and held target index
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= MCI_CIF_DEC_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  for (genvar k = 0; k < NUM_PRIV; k++) begin : g_priv
    mci_cif_priv_user_detect #(.USER_W(USER_W)) u_priv (
      .dv    (dv),
      .user  (req_user),
      .strap (strap_priv_user[k]),
      .priv  (priv_req[k])
    );
  end

  function automatic logic windows_ok();
    windows_ok = (TIMEOUT_CYCLES >= 2) && (NUM_TGT >= 1) && (NUM_TGT <= MCI_CIF_DEC_MAX_TGT);
    for (int i = 0; i < NUM_TGT; i++) begin
      if (TGT_BASE[i] > TGT_LIMIT[i]) windows_ok = 1'b0;
      for (int j = i + 1; j < NUM_TGT; j++) begin
        if (!((TGT_LIMIT[i] < TGT_BASE[j]) || (TGT_LIMIT[j] < TGT_BASE[i]))) windows_ok = 1'b0;
      end
    end
  endfunction

  `CALIPTRA_ASSERT_MUTEX(ERR_CIF_DEC_HIT_MUTEX, hit, clk, !rst_b)
  `CALIPTRA_ASSERT_INIT(ERR_CIF_DEC_WINDOWS, windows_ok(), clk)

endmodule

// File: tb/tb_mci_cif_multi_decode.sv
// Bench for mci_cif_multi_decode: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level
// reference model.
module tb_mci_cif_multi_decode;
  import mci_pkg::*;

  localparam int NT = 5, NP = 4, AW = 32, DW = 32, UW = 32, TO = 8;
  localparam int RW = AW + UW + 1 + DW/8 + DW;
  localparam logic [NT-1:0][AW-1:0] BASE = MCI_CIF_DEC_DEF_BASE;
  localparam logic [NT-1:0][AW-1:0] LIM  = MCI_CIF_DEC_DEF_LIMIT;
`ifdef MCI_CIF_DECODE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  cif_if #(.ADDR_W(AW), .DATA_W(DW), .USER_W(UW)) soc_if ();

  logic [NT-1:0]          tgt_dv, tgt_hold, tgt_error, tgt_en;
  logic [RW-1:0]          tgt_req_data;
  logic [NT-1:0][DW-1:0]  tgt_rdata;
  logic [NP-1:0][UW-1:0]  strap;
  logic [NP-1:0]          priv_req;
  logic                   timeout_pulse;
  logic [2:0]             timeout_tgt;
  logic [7:0]             timeout_cnt;

  mci_cif_multi_decode #(
    .NUM_TGT(NT), .NUM_PRIV(NP), .ADDR_W(AW), .DATA_W(DW), .USER_W(UW),
    .TGT_BASE(BASE), .TGT_LIMIT(LIM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_b(rst_b), .soc_resp_if(soc_if),
    .tgt_dv(tgt_dv), .tgt_req_data(tgt_req_data), .tgt_rdata(tgt_rdata),
    .tgt_hold(tgt_hold), .tgt_error(tgt_error), .tgt_en(tgt_en),
    .strap_priv_user(strap), .priv_req(priv_req),
    .timeout_pulse(timeout_pulse), .timeout_tgt(timeout_tgt), .timeout_cnt(timeout_cnt)
  );

  int checks = 0;
  int failures = 0;

  // current request as driven by the bench
  logic [AW-1:0] cur_addr;
  logic [UW-1:0] cur_user;
  logic [RW-1:0] cur_req;

  // reference model: outstanding held target, cycles since its first held cycle,
  // target being drained after an abort, and abort bookkeeping
  int pend_t = -1, waited = 0, drain_t = -1, last_tgt = 0, abort_cnt = 0;
  bit abort_now = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NT; i++)
      if (tgt_en[i] && a >= BASE[i] && a <= LIM[i]) return i;
    return -1;
  endfunction

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [UW-1:0] u);
    cur_addr = a;
    cur_user = u;
    cur_req  = {a, u, 1'b1, 4'hF, 32'($urandom)};
    soc_if.dv = v;
    soc_if.req_data = cur_req;
  endtask

  // compare the DUT against the model for this cycle, then advance the model
  task automatic model_cycle();
    logic [NT-1:0] e_dv;
    logic          e_hold, e_err;
    logic [DW-1:0] e_rd;
    logic [NP-1:0] e_priv;
    int            route, t;
    e_dv = '0; e_hold = 1'b0; e_err = 1'b0; e_rd = '0; route = -1;
    if (!rst_b) begin
      pend_t = -1; waited = 0; drain_t = -1; last_tgt = 0; abort_cnt = 0; abort_now = 1'b0;
    end
    if (abort_now) e_err = 1'b1;
    else if (drain_t >= 0) e_hold = soc_if.dv;
    else if (pend_t >= 0) begin
      if (soc_if.dv) route = pend_t;
    end else if (soc_if.dv) begin
      t = decode(cur_addr);
      if (t < 0) e_err = 1'b1;
      else route = t;
    end
    if (route >= 0) begin
      e_dv[route] = 1'b1;
      e_hold = tgt_hold[route];
      e_err  = tgt_error[route];
      e_rd   = tgt_rdata[route];
    end
    for (int k = 0; k < NP; k++) begin
      if (strap[k] == '0) e_priv[k] = 1'b0;
      else if (strap[k] == {UW{1'b1}}) e_priv[k] = soc_if.dv;
      else e_priv[k] = soc_if.dv && (cur_user == strap[k]);
    end
    chk("m_tgt_dv", tgt_dv, e_dv);
    chk("m_hold", soc_if.hold, e_hold);
    chk("m_error", soc_if.error, e_err);
    chk("m_rdata", soc_if.rdata, e_rd);
    chk("m_req_data", tgt_req_data, cur_req);
    chk("m_priv_req", priv_req, e_priv);
    chk("m_timeout_pulse", timeout_pulse, abort_now);
    chk("m_timeout_tgt", timeout_tgt, last_tgt);
    chk("m_timeout_cnt", timeout_cnt, abort_cnt);
    if (rst_b) begin
      if (abort_now) begin
        abort_now = 1'b0;
        drain_t = last_tgt;
      end else if (drain_t >= 0) begin
        if (!tgt_hold[drain_t]) drain_t = -1;
      end else if (pend_t >= 0) begin
        if (!soc_if.dv || !tgt_hold[pend_t]) pend_t = -1;
        else begin
          waited++;
          if (TO_EN && waited == TO) begin
            abort_now = 1'b1;
            last_tgt = pend_t;
            if (abort_cnt < 255) abort_cnt++;
            pend_t = -1;
          end
        end
      end else if (soc_if.dv) begin
        t = decode(cur_addr);
        if (t >= 0 && tgt_hold[t]) begin
          pend_t = t;
          waited = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int r, k;
    r = $urandom_range(0, NT);
    k = $urandom_range(0, 3);
    if (r == NT) return (k == 0) ? LIM[NT-1] + 32'd1 : (32'h8000_0000 | $urandom);
    case (k)
      0: return BASE[r];
      1: return LIM[r];
      2: return BASE[r] - 32'd1;
      default: return BASE[r] + ($urandom % (LIM[r] - BASE[r] + 32'd1));
    endcase
  endfunction

  int n_held;

  initial begin
    tgt_hold = '0; tgt_error = '0; tgt_en = '1;
    for (int i = 0; i < NT; i++) tgt_rdata[i] = 32'h1000_0000 * (i + 1) + 32'h5A;
    strap[0] = '0; strap[1] = '1; strap[2] = 32'h1234; strap[3] = 32'hDEAD_BEEF;
    drive(1'b0, 32'h0, 32'h0);

    // reset state
    tick();
    chk("rst_tgt_dv", tgt_dv, 5'b0);
    chk("rst_hold_err", {soc_if.hold, soc_if.error}, 2'b00);
    chk("rst_timeout", {timeout_pulse, timeout_tgt, timeout_cnt}, 12'h0);
    chk("rst_priv", priv_req, 4'b0000);
    adv();
    rst_b = 1'b1;

    // hit with no hold on target 2
    drive(1'b1, BASE[2] + 32'h40, 32'h0);
    tick();
    chk("hit2_tgt_dv", tgt_dv, 5'b00100);
    chk("hit2_hold_err", {soc_if.hold, soc_if.error}, 2'b00);
    chk("hit2_rdata", soc_if.rdata, 32'h3000_005A);
    adv();
    drive(1'b1, LIM[1], 32'h0);
    tick();
    chk("hit1_after_idle", tgt_dv, 5'b00010);
    adv();

    // held read on target 4; address moves to window 0 mid-transaction
    tgt_hold = 5'b10000;
    tgt_rdata[4] = 32'hCAFE_F00D;
    drive(1'b1, BASE[4], 32'h0);
    n_held = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (soc_if.hold === 1'b1 && tgt_dv === 5'b10000) n_held++;
      adv();
      drive(1'b1, BASE[0] + 32'h8, 32'h0);
    end
    chk("held_cycles", n_held, 3);
    tgt_hold = '0;
    tick();
    chk("held_done_tgt_dv", tgt_dv, 5'b10000);
    chk("held_done_hold", soc_if.hold, 1'b0);
    chk("held_done_rdata", soc_if.rdata, 32'hCAFE_F00D);
    adv();

    // miss outside all windows, then disabled target 1
    drive(1'b1, 32'hFFFF_0000, 32'h0);
    tick();
    chk("miss_resp", {tgt_dv, soc_if.hold, soc_if.error}, {5'b0, 1'b0, 1'b1});
    adv();
    tgt_en = 5'b11101;
    drive(1'b1, BASE[1] + 32'h10, 32'h0);
    tick();
    chk("disabled_resp", {tgt_dv, soc_if.hold, soc_if.error}, {5'b0, 1'b0, 1'b1});
    adv();
    tgt_en = '1;

    // privileged straps
    drive(1'b1, 32'hFFFF_0000, 32'h1234);
    tick();
    chk("priv_1234", priv_req, 4'b0110);
    adv();
    drive(1'b1, 32'hFFFF_0000, 32'hDEAD_BEEF);
    tick();
    chk("priv_beef", priv_req, 4'b1010);
    adv();

    // target 3 holds forever
    tgt_hold = 5'b01000;
    tgt_error = '0;
    tgt_rdata[3] = 32'h3333_3333;
    drive(1'b1, BASE[3], 32'h0);
    n_held = 0;
    for (int c = 0; c < TO; c++) begin
      tick();
      if (soc_if.hold === 1'b1 && soc_if.error === 1'b0 && tgt_dv === 5'b01000) n_held++;
      adv();
    end
    chk("to_held_cycles", n_held, TO);
    tick();
`ifdef MCI_CIF_DECODE_TIMEOUT_EN
    chk("abort_resp", {tgt_dv, soc_if.hold, soc_if.error}, {5'b0, 1'b0, 1'b1});
    chk("abort_rdata", soc_if.rdata, 32'h0);
    chk("abort_status", {timeout_pulse, timeout_tgt, timeout_cnt}, {1'b1, 3'd3, 8'd1});
    adv();
    drive(1'b1, BASE[2], 32'h0);
    tick();
    chk("drain_resp", {tgt_dv, soc_if.hold, soc_if.error, timeout_pulse}, {5'b0, 1'b1, 1'b0, 1'b0});
    adv();
    tgt_hold = '0;
    tick();
    chk("drain_last_resp", {tgt_dv, soc_if.hold}, {5'b0, 1'b1});
    adv();
    tick();
    chk("post_drain_tgt_dv", tgt_dv, 5'b00100);
    adv();
`else
    chk("no_to_still_held", {tgt_dv, soc_if.hold, soc_if.error}, {5'b01000, 1'b1, 1'b0});
    chk("no_to_status", {timeout_pulse, timeout_tgt, timeout_cnt}, 12'h0);
    adv();
    tgt_hold = '0;
    tick();
    chk("no_to_complete", {tgt_dv, soc_if.hold, soc_if.rdata}, {5'b01000, 1'b0, 32'h3333_3333});
    adv();
`endif

    // reset in the middle of a held transaction
    tgt_hold = 5'b10000;
    drive(1'b1, BASE[4], 32'h0);
    tick(); adv();
    tick(); adv();
    rst_b = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("rst_busy_outputs", {tgt_dv, soc_if.hold, soc_if.error, soc_if.rdata}, 40'h0);
    chk("rst_busy_status", {timeout_pulse, timeout_tgt, timeout_cnt}, 12'h0);
    adv();
    rst_b = 1'b1;
    tgt_hold = '0;
    drive(1'b1, BASE[2], 32'h0);
    tick();
    chk("post_rst_idle", tgt_dv, 5'b00100);
    adv();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NT; i++) begin
        tgt_hold[i]  = ($urandom_range(0, 3) != 0);
        tgt_rdata[i] = $urandom;
      end
      tgt_error = NT'($urandom);
      tgt_en    = ($urandom_range(0, 15) == 0) ? NT'($urandom) : '1;
      case ($urandom_range(0, 3))
        0: drive($urandom_range(0, 9) != 0, pick_addr(), 32'h1234);
        1: drive($urandom_range(0, 9) != 0, pick_addr(), 32'hDEAD_BEEF);
        default: drive($urandom_range(0, 9) != 0, pick_addr(), $urandom);
      endcase
      tick();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
